// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// synchronous flush and sticky error flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
module sync_fifo_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 64,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             winc,
    input  logic [WIDTH-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] TWO_CNT  = CNT_W'(2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             unf_q;
    logic             wacc;
    logic             racc;
    logic             mem_we;
    logic             mem_re;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign count         = cnt_q;
    assign wfull         = (cnt_q == FULL_CNT);
    assign rempty        = (cnt_q == '0);
    assign walmost_full  = (cnt_q >= AF_CNT);
    assign ralmost_empty = (cnt_q <= AE_CNT);
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

    assign wacc = winc & ~wfull & ~flush;
    assign racc = rinc & ~rempty & ~flush;

`ifdef SYNC_FIFO_FWFT_EN
    // The head word lives in rdata; the array holds only the words behind it.
    // A write bypasses the array when the output register would otherwise be left empty.
    logic mem_has_data;
    logic bypass;

    assign mem_has_data = (cnt_q >= TWO_CNT);
    assign mem_re       = racc & mem_has_data;
    assign bypass       = wacc & (rempty | (racc & ~mem_has_data));
    assign mem_we       = wacc & ~bypass;
    assign rvalid       = ~rempty;
`else
    logic rvalid_q;

    assign mem_re = racc;
    assign mem_we = wacc;
    assign rvalid = rvalid_q;
`endif

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            rdata <= '0;
`ifndef SYNC_FIFO_FWFT_EN
            rvalid_q <= 1'b0;
`endif
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
            rvalid_q <= 1'b0;
`endif
        end else begin
            if (mem_we) begin
                wptr <= ptr_inc(wptr);
            end
            if (mem_re) begin
                rptr <= ptr_inc(rptr);
            end
            case ({wacc, racc})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (winc & wfull) begin
                ovf_q <= 1'b1;
            end
            if (rinc & rempty) begin
                unf_q <= 1'b1;
            end
`ifdef SYNC_FIFO_FWFT_EN
            if (mem_re) begin
                rdata <= mem[rptr];
            end else if (bypass) begin
                rdata <= wdata;
            end
`else
            if (racc) begin
                rdata <= mem[rptr];
            end
            rvalid_q <= racc;
`endif
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param (DEPTH=6, AF=4, AE=1): directed steps then random traffic,
// checked every cycle against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 6;
    localparam int AF    = 4;
    localparam int AE    = 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             winc = 1'b0;
    logic [WIDTH-1:0] wdata = '0;
    logic             rinc = 1'b0;
    logic             wfull;
    logic             walmost_full;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             rempty;
    logic             ralmost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    sync_fifo_param #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .winc(winc),
        .wdata(wdata),
        .wfull(wfull),
        .walmost_full(walmost_full),
        .rinc(rinc),
        .rdata(rdata),
        .rvalid(rvalid),
        .rempty(rempty),
        .ralmost_empty(ralmost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_rdata = '0;
    logic             m_rvalid = 1'b0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("wfull", 32'(wfull), 32'(n == DEPTH));
        chk("rempty", 32'(rempty), 32'(n == 0));
        chk("walmost_full", 32'(walmost_full), 32'(n >= AF));
        chk("ralmost_empty", 32'(ralmost_empty), 32'(n <= AE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    task automatic model_edge(input logic r_st, input logic f, input logic w,
                              input logic [WIDTH-1:0] wd, input logic r);
        bit full  = (q.size() == DEPTH);
        bit empty = (q.size() == 0);
        if (r_st) begin
            q.delete();
            m_rdata  = '0;
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else if (f) begin
            q.delete();
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            logic [WIDTH-1:0] popped;
            if (w && full) m_ovf = 1'b1;
            if (r && empty) m_unf = 1'b1;
            m_rvalid = 1'b0;
            if (r && !empty) begin
                popped = q.pop_front();
`ifndef SYNC_FIFO_FWFT_EN
                m_rdata  = popped;
                m_rvalid = 1'b1;
`endif
            end
            if (w && !full) q.push_back(wd);
        end
`ifdef SYNC_FIFO_FWFT_EN
        // Head of queue is always visible; rdata holds when the queue drains.
        if (q.size() > 0) m_rdata = q[0];
        m_rvalid = (q.size() > 0);
`endif
    endtask

    task automatic step(input logic r_st, input logic f, input logic w,
                        input logic [WIDTH-1:0] wd, input logic r);
        @(negedge clk);
        rst   = r_st;
        flush = f;
        winc  = w;
        wdata = wd;
        rinc  = r;
        @(posedge clk);
        model_edge(r_st, f, w, wd, r);
        #1;
        check_all();
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        int bias;

        // Reset
        step(1, 0, 0, 8'h00, 0);
        step(1, 1, 1, 8'hFF, 1);
        step(0, 0, 0, 8'h00, 0);

        // Fill to full, then one rejected write
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'(8'h11 + i), 0);
        step(0, 0, 1, 8'h77, 0);
        // Drain in order, then one read past empty
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 1, 0, 8'h00, 0);

        // Alternate write/read across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 8'(8'h30 + i), 0);
            step(0, 0, 0, 8'h00, 1);
        end

        // Full with simultaneous write and read
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 8'(8'h50 + i), 0);
        step(0, 0, 1, 8'hEE, 1);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        // count=3, simultaneous write and read
        step(0, 0, 1, 8'h61, 1);
        step(0, 0, 1, 8'h62, 1);

        // Bring count to 5, then flush with a concurrent write
        step(0, 0, 1, 8'h63, 0);
        step(0, 0, 1, 8'h64, 0);
        held = rdata;
        step(0, 1, 1, 8'h65, 1);
        chk("flush_rdata_hold", 32'(rdata), 32'(held));
        step(0, 0, 0, 8'h00, 1);
        step(1, 0, 0, 8'h00, 0);

        // Write into empty then immediate read
        step(0, 0, 1, 8'hA5, 0);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);

        // Random traffic, bias alternating to reach full and empty
        for (int i = 0; i < 600; i++) begin
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 99) < bias,
                 8'($urandom),
                 $urandom_range(0, 99) >= bias);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next generation of the team's FIFO buffer, for datapaths that do not cross a clock domain. It generalises width and depth, including non-power-of-two depth. It adds an occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain, e.g. in front of a clk3-side consumer after the CDC FIFO.

## Interface
- WIDTH, 32, data word width (>=1)
- DEPTH, 64, number of entries (>=2, any integer, not restricted to powers of two)
- AF_LEVEL, DEPTH-4, walmost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 4, ralmost_empty asserts when count <= AE_LEVEL
- CNT_W (localparam) = $clog2(DEPTH+1)

- clk  in  1  sole clock, all state on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- flush  in  1  synchronous clear of contents and flags
- winc  in  1  write request
- wdata  in  WIDTH  write data
- wfull  out  1  FIFO full
- walmost_full  out  1  count >= AF_LEVEL
- rinc  in  1  read request
- rdata  out  WIDTH  read data, registered
- rvalid  out  1  rdata holds a newly popped word (see Configuration)
- rempty  out  1  no word readable
- ralmost_empty  out  1  count <= AE_LEVEL
- count  out  CNT_W  words currently held
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x WIDTH register array. Binary wptr/rptr in range 0..DEPTH-1. Each pointer wraps DEPTH-1 -> 0 explicitly; modulo-2^n wrap is not used.
- Write accepted (wacc) = winc & ~wfull & ~flush. Read accepted (racc) = rinc & ~rempty & ~flush.
- count next = count + wacc - racc. Simultaneous wacc and racc leaves count unchanged and is legal at any non-full, non-empty occupancy.
- wfull = (count == DEPTH). Write is rejected when full even if rinc is high the same cycle.
- rempty = (count == 0). A read is rejected when empty even if winc is high the same cycle.
- All flags are functions of registered state only. There is no combinational path from winc/rinc to any output.
- overflow sets on winc & wfull & ~flush. underflow sets on rinc & rempty & ~flush. Both hold until rst or flush.
- flush: in one cycle, pointers=0, count=0, overflow=underflow=0, rvalid=0. rdata holds its value. Same-cycle winc/rinc are ignored and set no error flag.
- rst has priority over flush. Every output takes its reset value: wfull=0, walmost_full=(AF_LEVEL==0), rempty=1, ralmost_empty=1, count=0, rdata=0, rvalid=0, overflow=0, underflow=0. Array contents are not reset.

## Timing
- Standard mode: racc at edge N loads rdata with mem[rptr] at edge N (visible cycle N+1). rvalid=1 for exactly cycle N+1. rdata holds otherwise.
- Write at edge N: count, rempty, walmost_full, wfull update in cycle N+1. A word written at N is readable (racc) from cycle N+1.
- Back-to-back reads at full rate: one word per cycle. Back-to-back writes: one per cycle until full.
- Latency write-to-rdata in an empty FIFO, standard mode: winc at N, rinc at N+1, data in cycle N+2.

## Configuration
- Macro SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through. The head word is presented on rdata whenever rempty=0.
  - rvalid = ~rempty.
  - rinc pops the head; the next word, if any, appears the following cycle.
  - count includes the word in the output register.
  - A write into an empty FIFO at edge N gives rempty=0 and rdata=wdata in cycle N+1.
  - rdata is still registered.
- Undefined: standard mode as in Timing.

## Test plan
- DEPTH=6: write 0x11..0x16 -> wfull=1 and count=6 after 6th edge. 7th winc -> overflow=1, count stays 6, contents unchanged. Read all -> 0x11..0x16 in order, rempty=1.
- DEPTH=6: 20 cycles of alternating writes and reads across pointer wrap (indices 5->0) -> data order preserved, no flag glitch.
- Full FIFO with winc=rinc=1 -> read accepted, write rejected, count 6->5, overflow=1. With count=3 and winc=rinc=1 -> count stays 3.
- AF_LEVEL=4, AE_LEVEL=1: fill 0->6 -> walmost_full rises when count reaches 4, ralmost_empty falls when count reaches 2.
- count=5, flush=1 with winc=1 -> next cycle count=0, rempty=1, overflow=underflow=0, rdata unchanged. rinc on empty -> underflow=1. rst -> all outputs at reset values.
- SYNC_FIFO_FWFT_EN defined: winc 0xA5 at edge N -> cycle N+1 rdata=0xA5, rvalid=1. rinc at N+1 -> rempty=1 at N+2.
